// File: rtl/alu_sequential.sv
// Sequential ALU: operands and opcode are entered one at a time from a shared
// bus on Enter rising edges; result and {N,Z,C,V,P} flags are registered, and a
// strobe in SHOW chains the result back as the next A operand.
module alu_sequential #(
    parameter int unsigned M = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [M-1:0] DataIn,
    input  logic [2:0]   OpIn,
    input  logic         Enter,
    input  logic         Clear,
    output logic [M-1:0] Result,
    output logic [4:0]   Flags,
    output logic         Valid,
    output logic [1:0]   State
);

    localparam int unsigned XW = M + 1;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        SHOW    = 2'd3
    } state_t;

    localparam logic [2:0] OP_SUB = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_ADC = 3'b101;
    localparam logic [2:0] OP_SBB = 3'b110;

    state_t         state_q, state_d;
    logic [M-1:0]   a_q, a_d;
    logic [M-1:0]   b_q, b_d;
    logic [M-1:0]   result_q, result_d;
    logic [4:0]     flags_q, flags_d;
    logic           cst_q, cst_d;
    logic           valid_q, valid_d;
    logic           enter_prev_q;
    logic           strobe_c;

    logic [XW-1:0]  ext_a, ext_b, ext_cin, alu_x;
    logic [M-1:0]   alu_r;
    logic           is_add, is_sub;
    logic           alu_n, alu_z, alu_c, alu_v, alu_p;

    // Single-cycle pulse on each Enter rising edge.
    assign strobe_c = Enter & ~enter_prev_q;

    // Combinational ALU on the captured operands, M+1 bits wide to expose carry/borrow.
    always_comb begin
        ext_a   = {1'b0, a_q};
        ext_b   = {1'b0, b_q};
        ext_cin = XW'(cst_q);
        alu_x   = '0;
        is_add  = 1'b0;
        is_sub  = 1'b0;
        case (OpIn)
            OP_SUB: begin
                alu_x  = ext_a - ext_b;
                is_sub = 1'b1;
            end
            OP_ADD: begin
                alu_x  = ext_a + ext_b;
                is_add = 1'b1;
            end
            OP_OR:  alu_x = ext_a | ext_b;
            OP_AND: alu_x = ext_a & ext_b;
            OP_XOR: alu_x = ext_a ^ ext_b;
            OP_ADC: begin
                alu_x  = ext_a + ext_b + ext_cin;
                is_add = 1'b1;
            end
            OP_SBB: begin
                alu_x  = ext_a - ext_b - ext_cin;
                is_sub = 1'b1;
            end
            default: alu_x = ext_b;
        endcase

        alu_r = alu_x[M-1:0];
        // Bit M of the widened result is carry for adds and borrow for subtracts.
        alu_c = (is_add | is_sub) & alu_x[M];
        if (is_add) begin
            alu_v = (alu_r[M-1] & ~a_q[M-1] & ~b_q[M-1]) |
                    (~alu_r[M-1] & a_q[M-1] & b_q[M-1]);
        end else if (is_sub) begin
            alu_v = (alu_r[M-1] & ~a_q[M-1] & b_q[M-1]) |
                    (~alu_r[M-1] & a_q[M-1] & ~b_q[M-1]);
        end else begin
            alu_v = 1'b0;
        end
        alu_n = alu_r[M-1];
        alu_z = (alu_r == '0);
        alu_p = ^alu_r;
    end

    // Next-state and datapath load decisions; everything holds without a strobe.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flags_d  = flags_q;
        cst_d    = cst_q;
        if (strobe_c) begin
            case (state_q)
                WAIT_A: begin
                    a_d     = DataIn;
                    state_d = WAIT_B;
                end
                WAIT_B: begin
                    b_d     = DataIn;
                    state_d = WAIT_OP;
                end
                WAIT_OP: begin
                    result_d = alu_r;
                    flags_d  = {alu_n, alu_z, alu_c, alu_v, alu_p};
                    cst_d    = alu_c;
                    state_d  = SHOW;
                end
                SHOW: begin
                    a_d     = result_q;
                    state_d = WAIT_B;
                end
                default: state_d = WAIT_A;
            endcase
        end
        valid_d = (state_d == SHOW);
    end

    // State register; reset wins over Clear, Clear discards any strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_A;
        end else if (Clear) begin
            state_q <= WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, result, flag, carry and valid registers.
    always_ff @(posedge clk) begin
        if (reset || Clear) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            cst_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            cst_q    <= cst_d;
            valid_q  <= valid_d;
        end
    end

    // Enter history; reset high so a button held through reset gives no strobe.
    always_ff @(posedge clk) begin
        if (reset || Clear) begin
            enter_prev_q <= 1'b1;
        end else begin
            enter_prev_q <= Enter;
        end
    end

    assign Result = result_q;
    assign Flags  = flags_q;
    assign Valid  = valid_q;
    assign State  = state_q;

endmodule

// File: tb/tb_alu_sequential.sv
// Bench for alu_sequential: directed scenarios plus random operand/opcode
// sequences, checked against an integer-arithmetic reference model.
module tb_alu_sequential;

    localparam int unsigned M = 8;
    localparam int HALF = 1 << (M - 1);
    localparam int MODV = 1 << M;

    logic         clk = 1'b0;
    logic         reset;
    logic [M-1:0] DataIn;
    logic [2:0]   OpIn;
    logic         Enter;
    logic         Clear;
    logic [M-1:0] Result;
    logic [4:0]   Flags;
    logic         Valid;
    logic [1:0]   State;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: 0=WAIT_A 1=WAIT_B 2=WAIT_OP 3=SHOW
    int ma, mb, mres, mflags, mcst, mstate;

    alu_sequential #(.M(M)) dut (
        .clk    (clk),
        .reset  (reset),
        .DataIn (DataIn),
        .OpIn   (OpIn),
        .Enter  (Enter),
        .Clear  (Clear),
        .Result (Result),
        .Flags  (Flags),
        .Valid  (Valid),
        .State  (State)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"},  32'(State),  32'(mstate));
        check({tag, "_result"}, 32'(Result), 32'(mres));
        check({tag, "_flags"},  32'(Flags),  32'(mflags));
        check({tag, "_valid"},  32'(Valid),  32'(mstate == 3));
    endtask

    task automatic model_reset();
        ma = 0; mb = 0; mres = 0; mflags = 0; mcst = 0; mstate = 0;
    endtask

    // Arithmetic on plain integers; signed overflow judged by range.
    task automatic model_compute(input int op);
        int sa, sb, full, sfull, r, c, v;
        bit arith, sub;
        sa = (ma >= HALF) ? ma - MODV : ma;
        sb = (mb >= HALF) ? mb - MODV : mb;
        arith = 1'b0; sub = 1'b0; sfull = 0;
        case (op)
            0: begin full = ma - mb;        sfull = sa - sb;        arith = 1; sub = 1; end
            1: begin full = ma + mb;        sfull = sa + sb;        arith = 1; end
            2: full = ma | mb;
            3: full = ma & mb;
            4: full = ma ^ mb;
            5: begin full = ma + mb + mcst; sfull = sa + sb + mcst; arith = 1; end
            6: begin full = ma - mb - mcst; sfull = sa - sb - mcst; arith = 1; sub = 1; end
            default: full = mb;
        endcase
        r = full & (MODV - 1);
        c = !arith ? 0 : (sub ? int'(full < 0) : int'(full >= MODV));
        v = !arith ? 0 : int'(sfull >= HALF || sfull < -HALF);
        mres   = r;
        mcst   = c;
        mflags = (int'(r >= HALF) << 4) | (int'(r == 0) << 3) | (c << 2) | (v << 1)
                 | ($countones(r) & 1);
    endtask

    task automatic model_strobe(input int d, input int op);
        case (mstate)
            0: begin ma = d; mstate = 1; end
            1: begin mb = d; mstate = 2; end
            2: begin model_compute(op); mstate = 3; end
            default: begin ma = mres; mstate = 1; end
        endcase
    endtask

    // One Enter press; checks right after the strobe edge and again one idle cycle later.
    task automatic press(input logic [M-1:0] d, input logic [2:0] op);
        DataIn = d;
        OpIn   = op;
        Enter  = 1'b1;
        tick();
        model_strobe(int'(d), int'(op));
        check_all("strobe");
        Enter  = 1'b0;
        DataIn = M'($urandom);
        OpIn   = 3'($urandom);
        tick();
        check_all("hold");
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        Enter = 1'($urandom);
        tick();
        Clear = 1'b0;
        Enter = 1'b0;
        model_reset();
        check_all("clear");
        tick();
    endtask

    initial begin
        reset = 1'b1; Clear = 1'b0; Enter = 1'b0; DataIn = '0; OpIn = '0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        check_all("reset");
        tick();

        // ADD with signed overflow
        press(8'h7F, 3'b000);
        press(8'h01, 3'b000);
        press(8'h00, 3'b001);
        check("t1_result", 32'(Result), 32'h80);
        check("t1_flags",  32'(Flags),  32'b10011);

        // SUB to zero, then SUB with borrow
        do_clear();
        press(8'h05, 3'b111); press(8'h05, 3'b111); press(8'h00, 3'b000);
        check("t2a_flags", 32'(Flags), 32'b01000);
        do_clear();
        press(8'h03, 3'b111); press(8'h05, 3'b111); press(8'h00, 3'b000);
        check("t2b_result", 32'(Result), 32'hFE);
        check("t2b_flags",  32'(Flags),  32'b10101);

        // Carry chain: ADD overflow then ADC of 0
        do_clear();
        press(8'hFF, 3'b000); press(8'h01, 3'b000); press(8'h00, 3'b001);
        check("t3a_flags", 32'(Flags), 32'b01100);
        press(8'h33, 3'b000);
        press(8'h00, 3'b000);
        press(8'h00, 3'b101);
        check("t3b_result", 32'(Result), 32'h01);
        check("t3b_flags",  32'(Flags),  32'b00001);

        // Logic op clears the carry seen by a following ADC
        do_clear();
        press(8'hFF, 3'b000); press(8'h01, 3'b000); press(8'h00, 3'b001);
        press(8'h00, 3'b000); press(8'hA5, 3'b000); press(8'h00, 3'b100);
        check("t4a_result", 32'(Result), 32'hA5);
        check("t4a_flags",  32'(Flags),  32'b10000);
        press(8'h00, 3'b000); press(8'h5B, 3'b000); press(8'h00, 3'b101);
        check("t4b_result", 32'(Result), 32'h00);

        // Enter held high for 10 cycles gives one transition
        do_clear();
        DataIn = 8'h42;
        Enter  = 1'b1;
        repeat (10) tick();
        Enter = 1'b0;
        model_strobe(32'h42, 0);
        tick();
        check_all("held");
        check("t5_state", 32'(State), 32'd1);

        // Clear together with a strobe in WAIT_OP
        press(8'h10, 3'b000);
        check("t6_pre_state", 32'(State), 32'd2);
        DataIn = 8'h77; OpIn = 3'b001;
        Enter = 1'b1; Clear = 1'b1;
        tick();
        Clear = 1'b0; Enter = 1'b0;
        model_reset();
        check_all("clr_strobe");
        tick();
        press(8'h09, 3'b000);
        press(8'h02, 3'b000);
        press(8'h00, 3'b110);

        // Reset in WAIT_B
        press(8'h00, 3'b000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check_all("rst_waitb");
        tick();

        // Random sequences with occasional clears
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 15) == 0) do_clear();
            else press(M'($urandom), 3'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
